// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core: one instruction at a time through a
// FETCH/DECODE/EXECUTE/MEM/WB FSM sharing a single valid/ready memory port.
module multicycle_core #(
  parameter int          ADDRESS_WIDTH = 16,
  parameter int          REG_COUNT     = 32,
  parameter logic [31:0] RESET_PC      = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_ready,
  output logic [31:0]              a0,
  output logic                     trap,
  output logic [31:0]              instret
);
  localparam int RIW = $clog2(REG_COUNT);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, TRAP} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_ADDI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JAL, OP_ILL
  } op_t;

  state_t      state;
  logic [31:0] pc, ir, opa, opb, imm, aluout;
  logic [31:0] regs [REG_COUNT];

  op_t         op;
  logic [31:0] dimm;
  logic        uses_rd, uses_rs1, uses_rs2, bad_reg;
  logic [31:0] ea, tgt, pc4;
  logic        taken;

  // Decode is purely a function of IR, which is stable from DECODE to WB.
  always_comb begin
    op       = OP_ILL;
    dimm     = '0;
    uses_rd  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (ir[6:0])
      7'b0110011: begin
        uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        if (ir[14:12] == 3'b000 && ir[31:25] == 7'h00)      op = OP_ADD;
        else if (ir[14:12] == 3'b000 && ir[31:25] == 7'h20) op = OP_SUB;
      end
      7'b0010011: begin
        uses_rd = 1'b1; uses_rs1 = 1'b1;
        dimm = {{20{ir[31]}}, ir[31:20]};
        if (ir[14:12] == 3'b000) op = OP_ADDI;
      end
      7'b0110111: begin
        uses_rd = 1'b1;
        dimm = {ir[31:12], 12'b0};
        op = OP_LUI;
      end
      7'b0000011: begin
        uses_rd = 1'b1; uses_rs1 = 1'b1;
        dimm = {{20{ir[31]}}, ir[31:20]};
        if (ir[14:12] == 3'b010) op = OP_LW;
      end
      7'b0100011: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dimm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        if (ir[14:12] == 3'b010) op = OP_SW;
      end
      7'b1100011: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dimm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        if (ir[14:12] == 3'b000)      op = OP_BEQ;
        else if (ir[14:12] == 3'b001) op = OP_BNE;
      end
      7'b1101111: begin
        uses_rd = 1'b1;
        dimm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        op = OP_JAL;
      end
      default: op = OP_ILL;
    endcase
  end

  assign bad_reg = (uses_rd  && int'(ir[11:7])  >= REG_COUNT) ||
                   (uses_rs1 && int'(ir[19:15]) >= REG_COUNT) ||
                   (uses_rs2 && int'(ir[24:20]) >= REG_COUNT);

  assign ea    = opa + imm;
  assign tgt   = pc + imm;
  assign pc4   = pc + 32'd4;
  assign taken = (opa == opb) ^ (op == OP_BNE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      opa     <= '0;
      opb     <= '0;
      imm     <= '0;
      aluout  <= '0;
      mem_req <= 1'b0;
      trap    <= 1'b0;
      instret <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          // mem_req is 0 only on the first FETCH after reset.
          if (!mem_req) mem_req <= 1'b1;
          else if (mem_ready) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (op == OP_ILL || bad_reg) begin
            trap  <= 1'b1;
            state <= TRAP;
          end else begin
            opa   <= regs[ir[15 +: RIW]];
            opb   <= regs[ir[20 +: RIW]];
            imm   <= dimm;
            state <= EXECUTE;
          end
        end
        EXECUTE: begin
          case (op)
            OP_ADD:  begin aluout <= opa + opb; state <= WB; end
            OP_SUB:  begin aluout <= opa - opb; state <= WB; end
            OP_ADDI: begin aluout <= opa + imm; state <= WB; end
            OP_LUI:  begin aluout <= imm;       state <= WB; end
            OP_LW, OP_SW: begin
              if (ea[1:0] != 2'b00) begin
                trap  <= 1'b1;
                state <= TRAP;
              end else begin
                aluout  <= ea;
                mem_req <= 1'b1;
                state   <= MEM;
              end
            end
            OP_BEQ, OP_BNE: begin
              // A misaligned control target would break the aligned-fetch guarantee.
              if (taken && tgt[1:0] != 2'b00) begin
                trap  <= 1'b1;
                state <= TRAP;
              end else begin
                pc      <= taken ? tgt : pc4;
                instret <= instret + 32'd1;
                mem_req <= 1'b1;
                state   <= FETCH;
              end
            end
            OP_JAL: begin
              if (tgt[1:0] != 2'b00) begin
                trap  <= 1'b1;
                state <= TRAP;
              end else begin
                aluout <= pc4;
                pc     <= tgt;
                state  <= WB;
              end
            end
            default: begin
              trap  <= 1'b1;
              state <= TRAP;
            end
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            if (op == OP_SW) begin
              // Request stays high: the next cycle is the following fetch.
              pc      <= pc4;
              instret <= instret + 32'd1;
              state   <= FETCH;
            end else begin
              aluout  <= mem_rdata;
              mem_req <= 1'b0;
              state   <= WB;
            end
          end
        end
        WB: begin
          if (ir[11:7] != 5'd0) regs[ir[7 +: RIW]] <= aluout;
          if (op != OP_JAL) pc <= pc4;
          instret <= instret + 32'd1;
          mem_req <= 1'b1;
          state   <= FETCH;
        end
        TRAP: state <= TRAP;
        default: state <= TRAP;
      endcase
    end
  end

  assign mem_addr  = (state == MEM) ? aluout[ADDRESS_WIDTH-1:0] : pc[ADDRESS_WIDTH-1:0];
  assign mem_we    = (state == MEM) && (op == OP_SW);
  assign mem_wdata = opb;
  assign a0        = regs[10];

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: vector table of small programs plus
// hand-written reset, trap-freeze, wait-state and RV32E sequences.
module tb_multicycle_core;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, a0, instret;
  logic        trap;

  logic        e_req, e_we, e_trap;
  logic [15:0] e_addr;
  logic [31:0] e_wdata, e_a0, e_instret;

  always #5 clk = ~clk;

  multicycle_core #(.ADDRESS_WIDTH(16), .REG_COUNT(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .a0(a0), .trap(trap), .instret(instret));

  // RV32E core that always fetches "addi x20,x0,1".
  multicycle_core #(.ADDRESS_WIDTH(16), .REG_COUNT(16), .RESET_PC(32'h0)) dut_e (
    .clk(clk), .rst(rst), .mem_req(e_req), .mem_we(e_we), .mem_addr(e_addr),
    .mem_wdata(e_wdata), .mem_rdata(32'h00100A13), .mem_ready(1'b1),
    .a0(e_a0), .trap(e_trap), .instret(e_instret));

  // Bench settings, written only by the stimulus process.
  logic [31:0] mem [16384];
  int          maxw;
  logic [15:0] end_pc;
  logic [15:0] stall_addr;

  // Memory responder and monitor state, written only by the monitor.
  int          cyc, wcnt, wtarget, hs_cnt, end_hits, stab_err, req_in_trap, st_cnt;
  logic        st_valid, in_xfer, x_we;
  logic [15:0] st_addr, x_addr;
  logic [31:0] st_data, x_wd, a0_prev;
  int          hs_cyc[$];
  logic [15:0] hs_addr[$];
  logic [31:0] a0_trace[$];

  always @(negedge clk) begin
    cyc++;
    mem_ready = 1'b0;
    if (!rst) begin
      wcnt = 0; wtarget = $urandom_range(maxw, 0);
      hs_cnt = 0; end_hits = 0; stab_err = 0; req_in_trap = 0; st_cnt = 0;
      st_valid = 1'b0; in_xfer = 1'b0; a0_prev = '0;
      hs_cyc.delete(); hs_addr.delete(); a0_trace.delete();
    end else begin
      if (trap && mem_req) req_in_trap++;
      if (a0 != a0_prev) begin a0_trace.push_back(a0); a0_prev = a0; end
      if (mem_req) begin
        if (in_xfer && (mem_addr != x_addr || mem_we != x_we || mem_wdata != x_wd)) stab_err++;
        if (wcnt >= wtarget && !(mem_addr == stall_addr && !mem_we)) begin
          mem_ready = 1'b1;
          mem_rdata = (st_valid && mem_addr == st_addr) ? st_data : mem[mem_addr[15:2]];
          if (mem_we) begin
            st_valid = 1'b1; st_addr = mem_addr; st_data = mem_wdata; st_cnt++;
          end
          hs_cnt++;
          hs_cyc.push_back(cyc);
          hs_addr.push_back(mem_addr);
          if (!mem_we && mem_addr == end_pc) end_hits++;
          wcnt = 0; wtarget = $urandom_range(maxw, 0);
          in_xfer = 1'b0;
        end else begin
          wcnt++;
          in_xfer = 1'b1; x_addr = mem_addr; x_we = mem_we; x_wd = mem_wdata;
        end
      end
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] prog [8];
    logic [15:0] end_pc;
    int          maxw;
    bit          halt_trap;
    logic [31:0] a0;
    logic        trap;
    logic [31:0] instret;
  } vec_t;

  vec_t vecs [7];

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic load_prog(input int idx);
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) mem[i] = vecs[idx].prog[i];
  endtask

  task automatic run_until(input int hits, input bit halt_trap, input string name);
    int k;
    for (k = 0; k < 600; k++) begin
      @(posedge clk); #2;
      if (end_hits >= hits || (halt_trap && trap)) break;
    end
    check({name, " timeout"}, (k < 600) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic run_vec(input int idx);
    load_prog(idx);
    maxw   = vecs[idx].maxw;
    end_pc = vecs[idx].end_pc;
    do_reset();
    run_until(1, vecs[idx].halt_trap, $sformatf("v%0d", idx));
    check($sformatf("v%0d a0", idx), a0, vecs[idx].a0);
    check($sformatf("v%0d trap", idx), {31'b0, trap}, {31'b0, vecs[idx].trap});
    check($sformatf("v%0d instret", idx), instret, vecs[idx].instret);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // countdown loop: addi a0,x0,5; addi a0,a0,-1; bne a0,x0,-4; jal x0,0
    vecs[0] = '{prog: '{32'h00500513, 32'hFFF50513, 32'hFE051EE3, 32'h0000006F, 0, 0, 0, 0},
                end_pc: 16'd12, maxw: 0, halt_trap: 1'b0, a0: 32'd0, trap: 1'b0, instret: 32'd11};
    // lui x1,1; addi x1,x1,4; addi x2,x0,0x55; sw x2,0(x1); lw a0,0(x1); jal x0,0
    vecs[1] = '{prog: '{32'h000010B7, 32'h00408093, 32'h05500113, 32'h0020A023, 32'h0000A503,
                        32'h0000006F, 0, 0},
                end_pc: 16'd20, maxw: 3, halt_trap: 1'b0, a0: 32'h55, trap: 1'b0, instret: 32'd5};
    // addi a0,x0,3; addi x0,x0,7; add a0,x0,x0; jal x0,0
    vecs[2] = '{prog: '{32'h00300513, 32'h00700013, 32'h00000533, 32'h0000006F, 0, 0, 0, 0},
                end_pc: 16'd12, maxw: 0, halt_trap: 1'b0, a0: 32'd0, trap: 1'b0, instret: 32'd3};
    // addi a0,x0,3; opcode 0x7F; addi a0,x0,9
    vecs[3] = '{prog: '{32'h00300513, 32'h0000007F, 32'h00900513, 0, 0, 0, 0, 0},
                end_pc: 16'hFFFF, maxw: 0, halt_trap: 1'b1, a0: 32'd3, trap: 1'b1, instret: 32'd1};
    // addi x1,x0,2; lw a0,0(x1)  (misaligned)
    vecs[4] = '{prog: '{32'h00200093, 32'h0000A503, 0, 0, 0, 0, 0, 0},
                end_pc: 16'hFFFF, maxw: 0, halt_trap: 1'b1, a0: 32'd0, trap: 1'b1, instret: 32'd1};
    // addi x1,x0,7; addi x2,x0,10; sub a0,x1,x2; jal x0,0
    vecs[5] = '{prog: '{32'h00700093, 32'h00A00113, 32'h40208533, 32'h0000006F, 0, 0, 0, 0},
                end_pc: 16'd12, maxw: 2, halt_trap: 1'b0, a0: 32'hFFFFFFFD, trap: 1'b0, instret: 32'd3};
    // addi x1,x0,1; beq x0,x0,8; addi a0,x0,9; jal a0,8; addi a0,x0,1; jal x0,0
    vecs[6] = '{prog: '{32'h00100093, 32'h00000463, 32'h00900513, 32'h0080056F, 32'h00100513,
                        32'h0000006F, 0, 0},
                end_pc: 16'd20, maxw: 0, halt_trap: 1'b0, a0: 32'd16, trap: 1'b0, instret: 32'd3};

    maxw = 0; end_pc = 16'hFFFF; stall_addr = 16'hFFFF;
    repeat (2) @(negedge clk);
    #1;
    check("reset mem_req", {31'b0, mem_req}, 32'd0);
    check("reset a0", a0, 32'd0);
    check("reset instret", instret, 32'd0);
    check("reset trap", {31'b0, trap}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_vec(i);
      if (i == 0) begin
        check("v0 trace len", a0_trace.size(), 32'd6);
        for (int j = 0; j < 6 && j < a0_trace.size(); j++)
          check($sformatf("v0 a0 step %0d", j), a0_trace[j], 32'(5 - j));
        // Zero-wait fetch spacing: addi, addi (4 cycles each), then taken bne (3).
        check("v0 cpi addi", hs_cyc[1] - hs_cyc[0], 32'd4);
        check("v0 cpi addi2", hs_cyc[2] - hs_cyc[1], 32'd4);
        check("v0 cpi bne", hs_cyc[3] - hs_cyc[2], 32'd3);
        check("v0 first fetch", {16'b0, hs_addr[0]}, 32'h0);
        // jal x0,0 retires once more before its target is fetched again.
        run_until(2, 1'b0, "v0 jal");
        check("v0 instret after jal", instret, 32'd12);
      end
      if (i == 1) begin
        check("v1 store count", st_cnt, 32'd1);
        check("v1 store addr", {16'b0, st_addr}, 32'h1004);
        check("v1 store data", st_data, 32'h55);
        check("v1 wait stability", stab_err, 32'd0);
      end
      if (i == 3 || i == 4) begin
        repeat (10) @(posedge clk);
        #2;
        check($sformatf("v%0d req in trap", i), req_in_trap, 32'd0);
        check($sformatf("v%0d frozen instret", i), instret, vecs[i].instret);
        check($sformatf("v%0d transfers", i), hs_cnt, 32'd2);
      end
    end

    // Reset during a stalled LW fetch, then a clean restart.
    load_prog(1);
    maxw = 0; end_pc = 16'd20; stall_addr = 16'd16;
    do_reset();
    begin
      int k;
      for (k = 0; k < 200; k++) begin
        @(posedge clk); #2;
        if (mem_req && mem_addr == 16'd16) break;
      end
      check("stall reached", (k < 200) ? 32'd1 : 32'd0, 32'd1);
    end
    repeat (3) @(posedge clk);
    #2;
    check("stall still req", {31'b0, mem_req}, 32'd1);
    check("stall instret", instret, 32'd4);
    rst = 1'b0;
    #1;
    check("async rst mem_req", {31'b0, mem_req}, 32'd0);
    check("async rst instret", instret, 32'd0);
    check("async rst a0", a0, 32'd0);
    stall_addr = 16'hFFFF;
    do_reset();
    run_until(1, 1'b0, "restart");
    check("restart first fetch", {16'b0, hs_addr[0]}, 32'h0);
    check("restart a0", a0, 32'h55);
    check("restart instret", instret, 32'd5);

    check("rv32e trap", {31'b0, e_trap}, 32'd1);
    check("rv32e mem_req", {31'b0, e_req}, 32'd0);
    check("rv32e instret", e_instret, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
